// File: rtl/alu_interface.sv
// UART-to-ALU frame sequencer: collects bytes A, B and OP, then sends the low byte of the ALU result.
// Optional inter-byte timeout is enabled by defining ALU_IF_TIMEOUT_EN.
module alu_interface #(
    parameter int N_BITS         = 8,
    parameter int N_OP           = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    input  logic [N_BITS-1:0] i_alu_res,
    input  logic              i_tx_done,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_OP-1:0]   o_OP,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_LATCH   = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
    logic [N_OP-1:0]   op_q, op_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic [N_BITS-1:0] rx_ext;
    logic [7:0]        res_byte;
    logic              timeout_hit;

    // Operand bytes are zero-extended or truncated to N_BITS; result is the low byte, zero-extended.
    if (N_BITS > 8) begin : g_wide
        assign rx_ext   = {{(N_BITS-8){1'b0}}, i_rx_data};
        assign res_byte = i_alu_res[7:0];
    end else if (N_BITS == 8) begin : g_byte
        assign rx_ext   = i_rx_data;
        assign res_byte = i_alu_res;
    end else begin : g_narrow
        assign rx_ext   = i_rx_data[N_BITS-1:0];
        assign res_byte = {{(8-N_BITS){1'b0}}, i_alu_res};
    end

`ifdef ALU_IF_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    logic          timeout_q;

    assign waiting     = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign timeout_hit = waiting && !i_rx_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d       = (waiting && (state_d == state_q)) ? cnt_q + CW'(1) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_hit;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (i_rx_done) state_d = S_WAIT_B;
            S_WAIT_B:  if (i_rx_done) state_d = S_WAIT_OP;
                       else if (timeout_hit) state_d = S_IDLE;
            S_WAIT_OP: if (i_rx_done) state_d = S_LATCH;
                       else if (timeout_hit) state_d = S_IDLE;
            S_LATCH:   state_d = S_SEND;
            S_SEND:    state_d = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE:    if (i_rx_done) a_d  = rx_ext;
            S_WAIT_B:  if (i_rx_done) b_d  = rx_ext;
            S_WAIT_OP: if (i_rx_done) op_d = i_rx_data[N_OP-1:0];
            S_LATCH: begin
                tx_data_d  = res_byte;
                tx_start_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_A        = a_q;
    assign o_B        = b_q;
    assign o_OP       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_alu_interface.sv
// Directed bench for alu_interface: frames through a behavioural ALU, dropped bytes, async reset,
// and (with ALU_IF_TIMEOUT_EN) the inter-byte timeout at TIMEOUT_CYCLES=16.
module tb_alu_interface;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_res;
    logic       tx_done;
    logic [7:0] a, b;
    logic [5:0] op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       timeout;
    logic [2:0] state;

    int n_checks = 0;
    int n_bad    = 0;
    int tx_pulses = 0;

    alu_interface #(
        .N_BITS(8),
        .N_OP(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .i_alu_res(alu_res),
        .i_tx_done(tx_done),
        .o_A(a),
        .o_B(b),
        .o_OP(op),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .o_busy(busy),
        .o_timeout(timeout),
        .o_state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU (MIPS-style function codes)
    always_comb begin
        alu_res = 8'h00;
        case (op)
            6'h20: alu_res = a + b;
            6'h22: alu_res = a - b;
            6'h24: alu_res = a & b;
            6'h25: alu_res = a | b;
            6'h26: alu_res = a ^ b;
            6'h27: alu_res = ~(a | b);
            6'h02: alu_res = a >> b;
            6'h03: alu_res = $signed(a) >>> b;
            default: alu_res = 8'h00;
        endcase
    end

    always @(negedge clk) if (tx_start) tx_pulses++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs are read on the falling edge
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] da, input logic [7:0] db,
                             input logic [7:0] dop, input logic [7:0] exp_res, input bit poke_tx);
        int p0;
        p0 = tx_pulses;
        send_byte(da);
        if (poke_tx) begin
            pulse_tx_done();
            check_eq({tag, "_txdone_ignored_state"}, state, 3'd1);
            check_eq({tag, "_txdone_ignored_busy"}, busy, 1'b1);
        end
        send_byte(db);
        send_byte(dop);
        check_eq({tag, "_latch_start_low"}, tx_start, 1'b0);
        check_eq({tag, "_latch_state"}, state, 3'd3);
        @(negedge clk);
        check_eq({tag, "_start_high"}, tx_start, 1'b1);
        check_eq({tag, "_tx_data"}, tx_data, exp_res);
        @(negedge clk);
        check_eq({tag, "_start_low"}, tx_start, 1'b0);
        check_eq({tag, "_A"}, a, da);
        check_eq({tag, "_B"}, b, db);
        check_eq({tag, "_OP"}, op, dop[5:0]);
        repeat (3) @(negedge clk);
        check_eq({tag, "_wait_tx_busy"}, busy, 1'b1);
        check_eq({tag, "_wait_tx_state"}, state, 3'd5);
        check_eq({tag, "_pulse_count"}, tx_pulses - p0, 1);
        check_eq({tag, "_no_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_A", a, 8'h00);
        check_eq("rst_B", b, 8'h00);
        check_eq("rst_OP", op, 6'h00);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("add", 8'h05, 8'h05, 8'h20, 8'h0A, 1'b0);
        pulse_tx_done();
        check_eq("add_idle_busy", busy, 1'b0);

        // i_tx_done while idle is ignored
        pulse_tx_done();
        check_eq("idle_txdone_busy", busy, 1'b0);
        check_eq("idle_txdone_state", state, 3'd0);

        run_frame("sub", 8'h05, 8'h0A, 8'h22, 8'hFB, 1'b1);
        pulse_tx_done();
        run_frame("and", 8'h1F, 8'hF8, 8'h24, 8'h18, 1'b0);
        pulse_tx_done();
        run_frame("nor", 8'h0F, 8'h14, 8'h27, 8'hE0, 1'b0);

        send_byte(8'h77);
        check_eq("drop_busy", busy, 1'b1);
        check_eq("drop_A", a, 8'h0F);
        check_eq("drop_B", b, 8'h14);
        pulse_tx_done();
        check_eq("drop_idle_busy", busy, 1'b0);
        check_eq("drop_idle_A", a, 8'h0F);

        run_frame("sra", 8'h18, 8'h02, 8'h03, 8'h06, 1'b0);
        // simultaneous rx and tx done in WAIT_TX: go idle, byte dropped
        @(negedge clk);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check_eq("simul_busy", busy, 1'b0);
        check_eq("simul_state", state, 3'd0);
        repeat (4) @(negedge clk);
        check_eq("hold_A", a, 8'h18);
        check_eq("hold_B", b, 8'h02);
        check_eq("hold_OP", op, 6'h03);
        check_eq("hold_tx_data", tx_data, 8'h06);

        // asynchronous reset mid-frame
        send_byte(8'h05);
        check_eq("pre_rst_A", a, 8'h05);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_A", a, 8'h00);
        check_eq("async_rst_OP", op, 6'h00);
        check_eq("async_rst_tx_data", tx_data, 8'h00);
        check_eq("async_rst_busy", busy, 1'b0);
        check_eq("async_rst_state", state, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 8'h03, 8'h04, 8'h20, 8'h07, 1'b0);
        pulse_tx_done();

`ifdef ALU_IF_TIMEOUT_EN
        send_byte(8'h05);
        repeat (15) @(negedge clk);
        check_eq("to_before_busy", busy, 1'b1);
        check_eq("to_before_pulse", timeout, 1'b0);
        @(negedge clk);
        check_eq("to_pulse", timeout, 1'b1);
        check_eq("to_busy", busy, 1'b0);
        check_eq("to_A_kept", a, 8'h05);
        @(negedge clk);
        check_eq("to_pulse_end", timeout, 1'b0);

        send_byte(8'h05);
        repeat (14) @(negedge clk);
        send_byte(8'h09);
        check_eq("to_win_pulse", timeout, 1'b0);
        check_eq("to_win_B", b, 8'h09);
        check_eq("to_win_state", state, 3'd2);
        send_byte(8'h20);
        repeat (2) @(negedge clk);
        check_eq("to_win_tx_data", tx_data, 8'h0E);
        pulse_tx_done();
`else
        // no timeout: waits indefinitely in WAIT_B
        send_byte(8'h05);
        repeat (40) @(negedge clk);
        check_eq("no_to_state", state, 3'd1);
        check_eq("no_to_pulse", timeout, 1'b0);
        send_byte(8'h09);
        send_byte(8'h20);
        repeat (2) @(negedge clk);
        check_eq("no_to_tx_data", tx_data, 8'h0E);
        pulse_tx_done();
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
